writeback_arbiter: RTL and testbench

- Shares the register-file write port (we3/a3/wd3) between the 5-stage pipeline's writeback stage and a long-latency execution unit (LU, e.g. mul/div).
- The LU result path is decoupled by a small FIFO.
- Pipeline writes win by default. A starvation counter forces a drain and stalls the pipeline for one cycle.
- Sits between the MEM/WB pipeline register plus result mux and the register file.

---
 rtl/writeback_arbiter_if.sv | 29 ++
 rtl/writeback_arbiter.sv | 130 +++++++++++++
 tb/tb_writeback_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Bundles the pipeline WB request, the LU result handshake and the register-file write port.
// The arbiter connects through the slave modport; the driving side uses master.
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5
);
  logic                      reg_write_w_i;
  logic [REGISTER_WIDTH-1:0] rd_w_i;
  logic [DATA_WIDTH-1:0]     result_w_i;
  logic                      lu_valid_i;
  logic [REGISTER_WIDTH-1:0] lu_rd_i;
  logic [DATA_WIDTH-1:0]     lu_data_i;
  logic                      lu_ready_o;
  logic                      we3_o;
  logic [REGISTER_WIDTH-1:0] a3_o;
  logic [DATA_WIDTH-1:0]     wd3_o;
  logic                      stall_w_o;
  logic                      lu_pending_o;

  modport master (
    output reg_write_w_i, rd_w_i, result_w_i, lu_valid_i, lu_rd_i, lu_data_i,
    input  lu_ready_o, we3_o, a3_o, wd3_o, stall_w_o, lu_pending_o
  );

  modport slave (
    input  reg_write_w_i, rd_w_i, result_w_i, lu_valid_i, lu_rd_i, lu_data_i,
    output lu_ready_o, we3_o, a3_o, wd3_o, stall_w_o, lu_pending_o
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port between the pipeline WB stage and a FIFO of LU results.
// Optional macro WB_BYPASS_EN: an LU result may be written the same cycle when nothing else wants the port.
module writeback_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  writeback_arbiter_if.slave      bus
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  typedef enum logic {PIPE, FORCE} stateE;

  stateE                     state_q;
  logic [STARVE_W-1:0]       starve_q, starve_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]          rdPtr_q, rdPtr_d;
  logic [REGISTER_WIDTH-1:0] rdMem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     dataMem_q [FIFO_DEPTH];

  logic pipeReq, fifoReq, luReady;
  logic grantPipe, deq, enq, bypass, goForce;

  // Grant decision: a forced drain beats everything, then the pipeline, then the FIFO head.
  always_comb begin
    pipeReq   = bus.reg_write_w_i && (bus.rd_w_i != '0);
    fifoReq   = (count_q != '0);
    luReady   = (count_q != CNT_W'(FIFO_DEPTH));
    grantPipe = 1'b0;
    deq       = 1'b0;
    bypass    = 1'b0;
    if (state_q == FORCE) begin
      deq = fifoReq;
    end else if (pipeReq) begin
      grantPipe = 1'b1;
    end else if (fifoReq) begin
      deq = 1'b1;
    end
`ifdef WB_BYPASS_EN
    else if (bus.lu_valid_i && (bus.lu_rd_i != '0)) begin
      bypass = 1'b1;
    end
`endif
    enq = bus.lu_valid_i && luReady && (bus.lu_rd_i != '0) && !bypass;
  end

  always_comb begin
    wrPtr_d  = enq ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d  = deq ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d  = count_q;
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CNT_W'(1);
    end
    // The head is starving only while it waits in PIPE; any drain or an empty FIFO clears the count.
    goForce  = 1'b0;
    starve_d = '0;
    if ((state_q == PIPE) && fifoReq && !deq) begin
      if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
        goForce = 1'b1;
      end else begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  always_comb begin
    bus.lu_ready_o   = 1'b0;
    bus.lu_pending_o = 1'b0;
    bus.stall_w_o    = 1'b0;
    bus.we3_o        = 1'b0;
    bus.a3_o         = '0;
    bus.wd3_o        = '0;
    if (!rst) begin
      bus.lu_ready_o   = luReady;
      bus.lu_pending_o = fifoReq;
      bus.stall_w_o    = (state_q == FORCE);
      if (grantPipe) begin
        bus.we3_o = 1'b1;
        bus.a3_o  = bus.rd_w_i;
        bus.wd3_o = bus.result_w_i;
      end else if (deq) begin
        bus.we3_o = 1'b1;
        bus.a3_o  = rdMem_q[rdPtr_q];
        bus.wd3_o = dataMem_q[rdPtr_q];
      end else if (bypass) begin
        bus.we3_o = 1'b1;
        bus.a3_o  = bus.lu_rd_i;
        bus.wd3_o = bus.lu_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PIPE;
      starve_q <= '0;
      count_q  <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
    end else begin
      case (state_q)
        PIPE:    state_q <= goForce ? FORCE : PIPE;
        FORCE:   state_q <= PIPE;
        default: state_q <= PIPE;
      endcase
      starve_q <= starve_d;
      count_q  <= count_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
    end
  end

  // Entry storage needs no reset; the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      rdMem_q[wrPtr_q]   <= bus.lu_rd_i;
      dataMem_q[wrPtr_q] <= bus.lu_data_i;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } entryT;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  writeback_arbiter_if #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW)) wbIf ();

  writeback_arbiter #(
    .DATA_WIDTH(DW), .REGISTER_WIDTH(RW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(wbIf)
  );

  // Control view {we3, stall, pending, ready} and write view {we3, a3, wd3}.
  function automatic logic [3:0] ctl();
    return {wbIf.we3_o, wbIf.stall_w_o, wbIf.lu_pending_o, wbIf.lu_ready_o};
  endfunction

  function automatic logic [RW+DW:0] wr();
    return {wbIf.we3_o, wbIf.a3_o, wbIf.wd3_o};
  endfunction

  task automatic applyStimulus(input logic r, input logic pw, input logic [RW-1:0] prd,
                               input logic [DW-1:0] pdata, input logic lv,
                               input logic [RW-1:0] lrd, input logic [DW-1:0] ldata);
    rst                = r;
    wbIf.reg_write_w_i = pw;
    wbIf.rd_w_i        = prd;
    wbIf.result_w_i    = pdata;
    wbIf.lu_valid_i    = lv;
    wbIf.lu_rd_i       = lrd;
    wbIf.lu_data_i     = ldata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1, 1, 5'd5, 32'h1, 1, 5'd6, 32'h2);
    @(negedge clk);
    checkCount++;
    if (ctl() !== 4'b0000) $display("[TB] FAIL reset_ctl got %b want %b", ctl(), 4'b0000);
    else passCount++;
    checkCount++;
    if (wr() !== '0) $display("[TB] FAIL reset_wr got %h want 0", wr());
    else passCount++;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if (ctl() !== 4'b0001) $display("[TB] FAIL reset_release got %b want %b", ctl(), 4'b0001);
    else passCount++;
    nextCycle();
    // Fill the FIFO behind a busy pipeline, then reset it away.
    applyStimulus(0, 1, 5'd5, 32'h11, 1, 5'd12, 32'hA);
    nextCycle();
    applyStimulus(0, 1, 5'd5, 32'h11, 1, 5'd13, 32'hB);
    nextCycle();
    applyStimulus(0, 1, 5'd5, 32'h11, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if (ctl() !== 4'b1010) $display("[TB] FAIL reset_full got %b want %b", ctl(), 4'b1010);
    else passCount++;
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkCount++;
      if (ctl() !== 4'b0001) $display("[TB] FAIL reset_midop_c%0d got %b want %b", k, ctl(), 4'b0001);
      else passCount++;
      nextCycle();
    end
  endtask

  task automatic test_idle_drain();
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
    @(negedge clk);
    checkCount++;
    if (BYPASS) begin
      if (wr() !== {1'b1, 5'd7, 32'hDEADBEEF}) $display("[TB] FAIL drain_bypass got %h want %h", wr(), {1'b1, 5'd7, 32'hDEADBEEF});
      else passCount++;
    end else begin
      if (ctl() !== 4'b0001) $display("[TB] FAIL drain_enq got %b want %b", ctl(), 4'b0001);
      else passCount++;
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if (BYPASS) begin
      if (ctl() !== 4'b0001) $display("[TB] FAIL drain_after_bypass got %b want %b", ctl(), 4'b0001);
      else passCount++;
    end else begin
      if (wr() !== {1'b1, 5'd7, 32'hDEADBEEF}) $display("[TB] FAIL drain_write got %h want %h", wr(), {1'b1, 5'd7, 32'hDEADBEEF});
      else passCount++;
    end
    nextCycle();
    @(negedge clk);
    checkCount++;
    if (ctl() !== 4'b0001) $display("[TB] FAIL drain_empty got %b want %b", ctl(), 4'b0001);
    else passCount++;
    nextCycle();
  endtask

  task automatic test_pipe_priority();
    applyStimulus(0, 1, 5'd5, 32'h11, 1, 5'd3, 32'h33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkCount++;
      if (wr() !== {1'b1, 5'd5, 32'h11}) $display("[TB] FAIL prio_pipe_c%0d got %h want %h", k, wr(), {1'b1, 5'd5, 32'h11});
      else passCount++;
      nextCycle();
      applyStimulus(0, 1, 5'd5, 32'h11, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if (wr() !== {1'b1, 5'd3, 32'h33}) $display("[TB] FAIL prio_fifo got %h want %h", wr(), {1'b1, 5'd3, 32'h33});
    else passCount++;
    nextCycle();
    @(negedge clk);
    checkCount++;
    if (ctl() !== 4'b0001) $display("[TB] FAIL prio_empty got %b want %b", ctl(), 4'b0001);
    else passCount++;
    nextCycle();
  endtask

  task automatic test_starvation();
    applyStimulus(0, 1, 5'd20, 32'h100, 1, 5'd9, 32'h99);
    nextCycle();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 1, 5'(20 + k), 32'h100 + k, 0, 0, 0);
      @(negedge clk);
      checkCount++;
      if ({ctl(), wr()} !== {4'b1011, 1'b1, 5'(20 + k), 32'h100 + k})
        $display("[TB] FAIL starve_wait_c%0d got %h want %h", k, {ctl(), wr()}, {4'b1011, 1'b1, 5'(20 + k), 32'h100 + k});
      else passCount++;
      nextCycle();
    end
    applyStimulus(0, 1, 5'd25, 32'h105, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if ({ctl(), wr()} !== {4'b1111, 1'b1, 5'd9, 32'h99})
      $display("[TB] FAIL starve_force got %h want %h", {ctl(), wr()}, {4'b1111, 1'b1, 5'd9, 32'h99});
    else passCount++;
    nextCycle();
    @(negedge clk);
    checkCount++;
    if ({ctl(), wr()} !== {4'b1001, 1'b1, 5'd25, 32'h105})
      $display("[TB] FAIL starve_held got %h want %h", {ctl(), wr()}, {4'b1001, 1'b1, 5'd25, 32'h105});
    else passCount++;
    nextCycle();
  endtask

  task automatic test_full_x0();
    applyStimulus(0, 1, 5'd6, 32'h6, 1, 5'd10, 32'hA0);
    nextCycle();
    applyStimulus(0, 1, 5'd6, 32'h6, 1, 5'd11, 32'hB0);
    nextCycle();
    applyStimulus(0, 1, 5'd6, 32'h6, 1, 5'd14, 32'hE0);
    @(negedge clk);
    checkCount++;
    if (ctl() !== 4'b1010) $display("[TB] FAIL full_ready got %b want %b", ctl(), 4'b1010);
    else passCount++;
    nextCycle();
    applyStimulus(0, 1, 5'd0, 32'hFF, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if (wr() !== {1'b1, 5'd10, 32'hA0}) $display("[TB] FAIL x0_pipe_drain got %h want %h", wr(), {1'b1, 5'd10, 32'hA0});
    else passCount++;
    nextCycle();
    applyStimulus(0, 1, 5'd6, 32'h6, 1, 5'd0, 32'hCC);
    @(negedge clk);
    checkCount++;
    if ({ctl(), wr()} !== {4'b1011, 1'b1, 5'd6, 32'h6})
      $display("[TB] FAIL x0_lu_accept got %h want %h", {ctl(), wr()}, {4'b1011, 1'b1, 5'd6, 32'h6});
    else passCount++;
    nextCycle();
    applyStimulus(0, 1, 5'd6, 32'h6, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if (ctl() !== 4'b1011) $display("[TB] FAIL x0_count_same got %b want %b", ctl(), 4'b1011);
    else passCount++;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if (wr() !== {1'b1, 5'd11, 32'hB0}) $display("[TB] FAIL x0_second got %h want %h", wr(), {1'b1, 5'd11, 32'hB0});
    else passCount++;
    nextCycle();
    @(negedge clk);
    checkCount++;
    if (ctl() !== 4'b0001) $display("[TB] FAIL x0_empty got %b want %b", ctl(), 4'b0001);
    else passCount++;
    nextCycle();
  endtask

  task automatic test_bypass();
    applyStimulus(0, 0, 0, 0, 1, 5'd4, 32'h42);
    @(negedge clk);
    checkCount++;
    if ({ctl(), wr()} !== (BYPASS ? {4'b1001, 1'b1, 5'd4, 32'h42} : {4'b0001, 1'b0, 5'd0, 32'h0}))
      $display("[TB] FAIL bypass_same got %h want bypass=%0d", {ctl(), wr()}, BYPASS);
    else passCount++;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkCount++;
    if ({ctl(), wr()} !== (BYPASS ? {4'b0001, 1'b0, 5'd0, 32'h0} : {4'b1011, 1'b1, 5'd4, 32'h42}))
      $display("[TB] FAIL bypass_next got %h want bypass=%0d", {ctl(), wr()}, BYPASS);
    else passCount++;
    nextCycle();
  endtask

  // Reference model: an ordered queue of pending results and a count of cycles the head has waited.
  task automatic test_random();
    entryT         mq[$];
    int            mWait  = 0;
    bit            mForce = 1'b0;
    logic          r, pw, lv;
    logic [RW-1:0] prd, lrd, expA;
    logic [DW-1:0] pdata, ldata, expD;
    bit            expWe, expStall, expPend, expReady, doDeq, doBypass, doEnq;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    nextCycle();
    for (int cyc = 0; cyc < 600; cyc++) begin
      r     = ($urandom_range(0, 59) == 0);
      pw    = ((cyc / 60) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3);
      prd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pdata = $urandom;
      lv    = $urandom_range(0, 1);
      lrd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ldata = $urandom;
      applyStimulus(r, pw, prd, pdata, lv, lrd, ldata);
      {expWe, expStall, expPend, expReady, doDeq, doBypass, doEnq} = '0;
      expA = '0;
      expD = '0;
      if (!r) begin
        expReady = (mq.size() < DEPTH);
        expPend  = (mq.size() > 0);
        if (mForce) begin
          expStall = 1'b1; expWe = 1'b1; expA = mq[0].rd; expD = mq[0].data; doDeq = 1'b1;
        end else if (pw && prd != 0) begin
          expWe = 1'b1; expA = prd; expD = pdata;
        end else if (mq.size() > 0) begin
          expWe = 1'b1; expA = mq[0].rd; expD = mq[0].data; doDeq = 1'b1;
        end else if (BYPASS && lv && lrd != 0) begin
          expWe = 1'b1; expA = lrd; expD = ldata; doBypass = 1'b1;
        end
        doEnq = lv && expReady && (lrd != 0) && !doBypass;
      end
      @(negedge clk);
      checkCount++;
      if (ctl() !== {expWe, expStall, expPend, expReady})
        $display("[TB] FAIL rand_ctl_c%0d got %b want %b", cyc, ctl(), {expWe, expStall, expPend, expReady});
      else passCount++;
      if (expWe || r) begin
        checkCount++;
        if (wr() !== {expWe, expA, expD})
          $display("[TB] FAIL rand_wr_c%0d got %h want %h", cyc, wr(), {expWe, expA, expD});
        else passCount++;
      end
      nextCycle();
      if (r) begin
        mq.delete();
        mWait  = 0;
        mForce = 1'b0;
      end else begin
        if (mForce) begin
          mForce = 1'b0;
          mWait  = 0;
        end else if (mq.size() > 0 && !doDeq) begin
          mWait++;
          if (mWait >= LIMIT) begin
            mForce = 1'b1;
            mWait  = 0;
          end
        end else begin
          mWait = 0;
        end
        if (doDeq) void'(mq.pop_front());
        if (doEnq) mq.push_back('{rd: lrd, data: ldata});
      end
    end
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_idle_drain();
    test_pipe_priority();
    test_starvation();
    test_full_x0();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
